mod_phase_gen: RTL and testbench

Keyed phase generator for the digital modulator. It consumes the registered 32-bit frequency control words and produces the sine-ROM address and amplitude gate that drive the waveform lookup. The data symbols that key it come from an internal PRBS7 source or from an external data bit. It supports carrier-only, ASK, FSK and BPSK modes.

---
 rtl/mod_phase_gen.sv | 108 ++++++++++
 tb/tb_mod_phase_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_phase_gen.sv
// mod_phase_gen: keyed phase generator for the digital modulator.
// Turns the 32-bit frequency control words into a sine-ROM address and an
// amplitude gate, keyed by a symbol stream for carrier/ASK/FSK/BPSK modes.
// Optional feature macro: PRBS7_SRC_EN -- when defined, an internal PRBS7
// LFSR supplies the symbol bits; otherwise ext_bit is sampled on each
// symbol boundary.
module mod_phase_gen #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned SYM_DIV_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [31:0]          fword0,
    input  logic [31:0]          fword1,
    input  logic [SYM_DIV_W-1:0] sym_div,
    input  logic                 ext_bit,
    output logic [ADDR_W-1:0]    rom_addr,
    output logic                 amp_en,
    output logic                 sym_bit,
    output logic                 sym_strobe
);

    localparam int unsigned ACC_W = 32;
    localparam logic [1:0] MODE_ASK  = 2'b01;
    localparam logic [1:0] MODE_FSK  = 2'b10;
    localparam logic [1:0] MODE_BPSK = 2'b11;
    // Half a sine period: the 180 degree offset for BPSK.
    localparam logic [ADDR_W-1:0] HALF_TURN = {1'b1, {(ADDR_W-1){1'b0}}};

    logic [ACC_W-1:0]     r_acc;
    logic [SYM_DIV_W-1:0] r_sym_cnt;
    logic                 r_sym_bit;
    logic                 r_sym_strobe;
    logic [ADDR_W-1:0]    r_rom_addr;
    logic                 r_amp_en;

    logic                 w_wrap;
    logic [ACC_W-1:0]     w_step;
    logic [ADDR_W-1:0]    w_offset;
    logic                 w_next_bit;
    logic                 w_unused;

`ifdef PRBS7_SRC_EN
    logic [6:0] r_lfsr;

    // PRBS7 (x^7+x^6+1) data source, advancing once per symbol.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= 7'h7F;
        end else if (en && w_wrap) begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        end
    end

    assign w_next_bit = r_lfsr[6];
    assign w_unused   = ^{r_acc, ext_bit};
`else
    assign w_next_bit = ext_bit;
    assign w_unused   = ^r_acc;
`endif

    // Symbol boundary, frequency step and phase offset for this cycle.
    always_comb begin
        w_wrap   = (r_sym_cnt >= sym_div);
        w_step   = fword0;
        w_offset = '0;
        if (mode == MODE_FSK && r_sym_bit) begin
            w_step = fword1;
        end
        if (mode == MODE_BPSK && r_sym_bit) begin
            w_offset = HALF_TURN;
        end
    end

    // Phase accumulator, symbol timer and registered outputs; en=0 freezes all.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_sym_cnt    <= '0;
            r_sym_bit    <= 1'b0;
            r_sym_strobe <= 1'b0;
            r_rom_addr   <= '0;
            r_amp_en     <= 1'b0;
        end else if (en) begin
            r_acc      <= r_acc + w_step;
            r_rom_addr <= r_acc[ACC_W-1 -: ADDR_W] + w_offset;
            r_amp_en   <= (mode == MODE_ASK) ? r_sym_bit : 1'b1;
            if (w_wrap) begin
                r_sym_cnt    <= '0;
                r_sym_bit    <= w_next_bit;
                r_sym_strobe <= 1'b1;
            end else begin
                r_sym_cnt    <= r_sym_cnt + SYM_DIV_W'(1);
                r_sym_strobe <= 1'b0;
            end
        end else begin
            r_sym_strobe <= 1'b0;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign amp_en     = r_amp_en;
    assign sym_bit    = r_sym_bit;
    assign sym_strobe = r_sym_strobe;

endmodule

// File: tb/tb_mod_phase_gen.sv
// Self-checking bench for mod_phase_gen: directed steps from the test plan
// plus randomized traffic, checked against a cycle-level behavioural model.
module tb_mod_phase_gen;

    localparam int unsigned AW  = 10;
    localparam int unsigned SDW = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           en;
    logic [1:0]     mode;
    logic [31:0]    fword0;
    logic [31:0]    fword1;
    logic [SDW-1:0] sym_div;
    logic           ext_bit;
    logic [AW-1:0]  rom_addr;
    logic           amp_en;
    logic           sym_bit;
    logic           sym_strobe;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (phase in turns scaled by 2^32, symbol counters).
    longint m_acc;
    int     m_cnt;
    logic   m_bit;
    logic   m_strobe;
    int     m_addr;
    logic   m_amp;
    int     m_idx;
    logic   prbs [0:126];

    mod_phase_gen #(.ADDR_W(AW), .SYM_DIV_W(SDW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode),
        .fword0     (fword0),
        .fword1     (fword1),
        .sym_div    (sym_div),
        .ext_bit    (ext_bit),
        .rom_addr   (rom_addr),
        .amp_en     (amp_en),
        .sym_bit    (sym_bit),
        .sym_strobe (sym_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_bit = 1'b0; m_strobe = 1'b0;
        m_addr = 0; m_amp = 1'b0; m_idx = 0;
    endtask

    function automatic logic next_data();
`ifdef PRBS7_SRC_EN
        return prbs[m_idx % 127];
`else
        return ext_bit;
`endif
    endfunction

    // One enabled edge of the modulator, from the behavioural rules.
    task automatic model_edge();
        longint stp;
        int     off;
        logic   wrap;
        if (!en) begin
            m_strobe = 1'b0;
            return;
        end
        wrap   = (m_cnt >= int'(sym_div));
        stp    = (mode == 2'b10 && m_bit) ? longint'(fword1) : longint'(fword0);
        off    = (mode == 2'b11 && m_bit) ? (1 << (AW - 1)) : 0;
        m_addr = (int'(m_acc >> (32 - AW)) + off) % (1 << AW);
        m_amp  = (mode == 2'b01) ? m_bit : 1'b1;
        m_acc  = (m_acc + stp) % (longint'(1) << 32);
        if (wrap) begin
            m_bit = next_data();
            m_idx++;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        m_strobe = wrap;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(m_addr));
        chk({tag, ".amp_en"}, 32'(amp_en), 32'(m_amp));
        chk({tag, ".sym_bit"}, 32'(sym_bit), 32'(m_bit));
        chk({tag, ".sym_strobe"}, 32'(sym_strobe), 32'(m_strobe));
    endtask

    // Clock edge, model update, then compare at the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // PRBS7 reference: s[n+7] = s[n] ^ s[n+1], seed of seven ones.
        for (int i = 0; i < 7; i++) prbs[i] = 1'b1;
        for (int i = 7; i < 127; i++) prbs[i] = prbs[i-7] ^ prbs[i-6];

        // Reset held with the block enabled: everything stays at zero.
        reset_n = 1'b0; en = 1'b1; mode = 2'b00;
        fword0 = 32'h0100_0000; fword1 = 32'h0; sym_div = SDW'(3); ext_bit = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick("rst_hold");
        chk("rst.rom_addr", 32'(rom_addr), 32'd0);
        chk("rst.amp_en", 32'(amp_en), 32'd0);
        chk("rst.sym_strobe", 32'(sym_strobe), 32'd0);
        reset_n = 1'b1;

        // Release: rom_addr 0,4,8,12,...; amp_en high; first strobe after 4 cycles.
        for (int k = 1; k <= 6; k++) begin
            tick("rel");
            chk("rel.addr_seq", 32'(rom_addr), 32'(4 * (k - 1)));
            chk("rel.amp_en", 32'(amp_en), 32'd1);
            chk("rel.strobe_at4", 32'(sym_strobe), 32'(k == 4));
        end

        // Carrier at half rate: rom_addr alternates 0/512, data bits ignored.
        do_reset();
        fword0 = 32'h8000_0000; sym_div = SDW'(1);
        for (int k = 1; k <= 8; k++) begin
            ext_bit = 1'($urandom);
            tick("car");
            chk("car.alt", 32'(rom_addr), (k % 2 == 0) ? 32'd512 : 32'd0);
        end

        // FSK with steps of 1 and 4 addresses per cycle.
        do_reset();
        mode = 2'b10; fword0 = 32'h0040_0000; fword1 = 32'h0100_0000; sym_div = SDW'(3);
        for (int k = 0; k < 48; k++) begin
            ext_bit = (k / 4) % 2 == 0;
            tick("fsk");
        end

        // BPSK with zero frequency: rom_addr is 512 one cycle after sym_bit=1.
        do_reset();
        mode = 2'b11; fword0 = 32'h0;
        for (int k = 0; k < 24; k++) begin
            logic prev_bit;
            ext_bit  = (k / 4) % 2 == 0;
            prev_bit = m_bit;
            tick("bpsk");
            chk("bpsk.flip", 32'(rom_addr), prev_bit ? 32'd512 : 32'd0);
        end

        // ASK: amp_en follows sym_bit a cycle later, phase fixed.
        mode = 2'b01;
        for (int k = 0; k < 24; k++) begin
            logic prev_bit;
            ext_bit  = (k / 4) % 2 == 1;
            prev_bit = m_bit;
            tick("ask");
            chk("ask.gate", 32'(amp_en), 32'(prev_bit));
            chk("ask.addr", 32'(rom_addr), 32'd0);
        end

        // en gating mid-symbol: outputs frozen, no strobe, period stretched.
        do_reset();
        mode = 2'b00; fword0 = 32'h0100_0000; sym_div = SDW'(5);
        for (int k = 0; k < 8; k++) tick("pre_gate");
        begin
            logic [AW-1:0] frozen;
            frozen = rom_addr;
            en = 1'b0;
            for (int k = 0; k < 5; k++) begin
                tick("gate");
                chk("gate.frozen", 32'(rom_addr), 32'(frozen));
                chk("gate.nostrobe", 32'(sym_strobe), 32'd0);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 10; k++) tick("post_gate");

        // sym_div=0: strobe on every enabled cycle; 130 symbols cover a PRBS period.
        sym_div = SDW'(0);
        for (int k = 0; k < 130; k++) begin
            ext_bit = 1'($urandom);
            tick("div0");
            chk("div0.strobe", 32'(sym_strobe), 32'd1);
        end

        // sym_div lowered below the running count forces an immediate wrap.
        do_reset();
        sym_div = SDW'(100);
        for (int k = 0; k < 50; k++) tick("div100");
        sym_div = SDW'(2);
        tick("div_drop");
        chk("div_drop.strobe", 32'(sym_strobe), 32'd1);
        tick("div_drop2");
        chk("div_drop2.strobe", 32'(sym_strobe), 32'd0);

        // Async reset mid-symbol clears at once and restarts the timer.
        sym_div = SDW'(5);
        for (int k = 0; k < 3; k++) tick("pre_arst");
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst.rom_addr", 32'(rom_addr), 32'd0);
        chk("arst.sym_bit", 32'(sym_bit), 32'd0);
        chk("arst.amp_en", 32'(amp_en), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick("arst_run");
            chk("arst.first_strobe", 32'(sym_strobe), 32'(k == 6));
        end

        // Randomized traffic across all modes against the model.
        for (int md = 0; md < 4; md++) begin
            mode = 2'(md);
            for (int k = 0; k < 120; k++) begin
                if (k % 20 == 0) begin
                    fword0  = $urandom;
                    fword1  = $urandom;
                    sym_div = SDW'($urandom_range(0, 4));
                end
                en      = ($urandom_range(0, 9) != 0);
                ext_bit = 1'($urandom);
                tick("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
